// File: rtl/gpioemu.sv
// Memory-mapped GPIO emulator with an iterative-subtraction GCD engine on a strobe bus.
// Strobes are synchronised and edge-detected so a held strobe performs exactly one access.
module gpioemu #(
  parameter logic [15:0] ADDR_A1 = 16'h00F8,
  parameter logic [15:0] ADDR_A2 = 16'h00FC,
  parameter logic [15:0] ADDR_W  = 16'h0100,
  parameter logic [15:0] ADDR_S  = 16'h0104
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic        srd_s_q, srd_h_q, swr_s_q, swr_h_q, lat_s_q, lat_h_q;
  logic [31:0] gpio_in_s_q;

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      srd_s_q     <= 1'b0;
      srd_h_q     <= 1'b0;
      swr_s_q     <= 1'b0;
      swr_h_q     <= 1'b0;
      lat_s_q     <= 1'b0;
      lat_h_q     <= 1'b0;
      gpio_in_s_q <= '0;
    end else begin
      srd_s_q     <= srd;
      srd_h_q     <= srd_s_q;
      swr_s_q     <= swr;
      swr_h_q     <= swr_s_q;
      lat_s_q     <= gpio_latch;
      lat_h_q     <= lat_s_q;
      gpio_in_s_q <= gpio_in;
    end
  end

  logic rd_edge, wr_edge, lat_edge, start;
  assign rd_edge  = srd_s_q & ~srd_h_q;
  assign wr_edge  = swr_s_q & ~swr_h_q;
  assign lat_edge = lat_s_q & ~lat_h_q;
  assign start    = wr_edge && (saddress == ADDR_A2);

  state_e      state_q;
  logic [31:0] a1_q, a2_q, w_q, a_q, b_q;
  logic        busy_q, done_q;
  // Reads are served one clock after the edge so a coincident write is already visible.
  logic        rd_pend_q;
  logic [15:0] rd_addr_q;

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state_q        <= StIdle;
      a1_q           <= '0;
      a2_q           <= '0;
      w_q            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_addr_q      <= '0;
      sdata_out      <= '0;
      gpio_out       <= '0;
      gpio_in_s_insp <= '0;
    end else begin
      if (lat_edge) gpio_in_s_insp <= gpio_in_s_q;
      if (wr_edge && (saddress == ADDR_A1)) a1_q <= sdata_in;

      rd_pend_q <= rd_edge;
      if (rd_edge) rd_addr_q <= saddress;
      if (rd_pend_q) begin
        case (rd_addr_q)
          ADDR_A1: sdata_out <= a1_q;
          ADDR_A2: sdata_out <= a2_q;
          ADDR_W:  sdata_out <= w_q;
          ADDR_S:  sdata_out <= {30'b0, done_q, busy_q};
          default: sdata_out <= '0;
        endcase
      end

      // A start always wins, which also aborts a run already in progress.
      if (start) begin
        a2_q <= sdata_in;
        a_q  <= a1_q;
        b_q  <= sdata_in;
        if (a1_q == '0 && sdata_in == '0) begin
          w_q      <= '0;
          gpio_out <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end else begin
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= StRun;
        end
      end else begin
        case (state_q)
          StIdle: ;
          StRun: begin
            if (b_q == '0 || a_q == b_q) begin
              w_q      <= a_q;
              gpio_out <= a_q;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= StIdle;
            end else if (a_q == '0) begin
              w_q      <= b_q;
              gpio_out <= b_q;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= StIdle;
            end else if (a_q > b_q) begin
              a_q <= a_q - b_q;
            end else begin
              b_q <= b_q - a_q;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpioemu.sv
// Self-checking bench for gpioemu: bus reads push expected data to a scoreboard queue,
// which is popped and compared once the registered read data is available.
module tb_gpioemu;

  localparam logic [15:0] AddrA1 = 16'h00F8;
  localparam logic [15:0] AddrA2 = 16'h00FC;
  localparam logic [15:0] AddrW  = 16'h0100;
  localparam logic [15:0] AddrS  = 16'h0104;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  gpioemu dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .saddress      (saddress),
    .srd           (srd),
    .swr           (swr),
    .sdata_in      (sdata_in),
    .sdata_out     (sdata_out),
    .gpio_in       (gpio_in),
    .gpio_latch    (gpio_latch),
    .gpio_out      (gpio_out),
    .gpio_in_s_insp(gpio_in_s_insp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    saddress = addr;
    sdata_in = data;
    swr      = 1'b1;
    tick(2);
    swr = 1'b0;
    tick(3);
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, sdata_out, e);
    end
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    saddress = addr;
    srd      = 1'b1;
    tick(2);
    srd = 1'b0;
    tick(2);
    pop_check();
  endtask

  task automatic wait_gpio_out(input logic [31:0] exp, input int budget, input string tag);
    int k;
    k = 0;
    while (gpio_out !== exp && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, gpio_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    n_reset = 1'b0;
    tick(2);

    // Reset state
    bus_read(AddrA1, 32'h0, "rst_a1");
    bus_read(AddrA2, 32'h0, "rst_a2");
    bus_read(AddrW,  32'h0, "rst_w");
    bus_read(AddrS,  32'h0, "rst_s");
    check_eq("rst_gpio_out", gpio_out, 32'h0);
    check_eq("rst_insp", gpio_in_s_insp, 32'h0);

    // gcd(39, 9) = 3
    bus_write(AddrA1, 32'h27);
    bus_write(AddrA2, 32'h9);
    tick(40);
    bus_read(AddrW,  32'h3,  "gcd39_9_w");
    bus_read(AddrS,  32'h2,  "gcd39_9_s");
    bus_read(AddrA1, 32'h27, "gcd39_9_a1");
    bus_read(AddrA2, 32'h9,  "gcd39_9_a2");
    check_eq("gcd39_9_gpio_out", gpio_out, 32'h3);

    // Long run: busy visible, W holds previous result
    bus_write(AddrA1, 32'd300);
    bus_write(AddrA2, 32'd7);
    bus_read(AddrS, 32'h1, "busy_s");
    bus_read(AddrW, 32'h3, "busy_w_prev");
    tick(100);
    bus_read(AddrS, 32'h2, "long_s_done");
    bus_read(AddrW, 32'h1, "long_w");

    // Zero operands and the all-ones boundary
    bus_write(AddrA1, 32'h0);
    bus_write(AddrA2, 32'h15);
    tick(10);
    bus_read(AddrW, 32'h15, "zero_a1_w");
    bus_write(AddrA2, 32'h0);
    tick(5);
    bus_read(AddrW, 32'h0, "both_zero_w");
    bus_read(AddrS, 32'h2, "both_zero_s");
    bus_write(AddrA1, 32'hFFFF_FFFF);
    bus_write(AddrA2, 32'hFFFF_FFFF);
    wait_gpio_out(32'hFFFF_FFFF, 20, "ones_gpio_out");
    bus_read(AddrW, 32'hFFFF_FFFF, "ones_w");

    // Restart mid-run: gcd(39, 26) = 13
    bus_write(AddrA1, 32'h27);
    saddress = AddrA2;
    sdata_in = 32'h9;
    swr      = 1'b1;
    tick(2);
    swr = 1'b0;
    tick(1);
    sdata_in = 32'h1A;
    swr      = 1'b1;
    tick(2);
    swr = 1'b0;
    tick(30);
    bus_read(AddrW, 32'hD, "restart_w");
    bus_read(AddrS, 32'h2, "restart_s");

    // Reset mid-run
    bus_write(AddrA1, 32'd300);
    bus_write(AddrA2, 32'd7);
    tick(3);
    n_reset = 1'b1;
    tick(1);
    n_reset = 1'b0;
    tick(2);
    bus_read(AddrS,  32'h0, "midrst_s");
    bus_read(AddrW,  32'h0, "midrst_w");
    bus_read(AddrA1, 32'h0, "midrst_a1");
    check_eq("midrst_gpio_out", gpio_out, 32'h0);

    // GPIO snapshot
    gpio_in    = 32'hA5A5_0001;
    gpio_latch = 1'b1;
    tick(2);
    gpio_latch = 1'b0;
    tick(3);
    gpio_in = 32'h1234_5678;
    tick(5);
    check_eq("latch_insp", gpio_in_s_insp, 32'hA5A5_0001);

    // Held write strobe performs a single write
    saddress = AddrA1;
    sdata_in = 32'h5;
    swr      = 1'b1;
    tick(4);
    sdata_in = 32'h7;
    tick(5);
    swr = 1'b0;
    tick(3);
    bus_read(AddrA1, 32'h5, "held_swr_a1");

    // Unmapped read
    bus_read(16'h0200, 32'h0, "unmapped");

    // Coincident read and write returns the post-write value
    exp_q.push_back(32'h55);
    tag_q.push_back("rd_wr_same");
    saddress = AddrA1;
    sdata_in = 32'h55;
    swr      = 1'b1;
    srd      = 1'b1;
    tick(2);
    swr = 1'b0;
    srd = 1'b0;
    tick(2);
    pop_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpioemu.md
Name: gpioemu

Overview:
- Memory-mapped GPIO emulator peripheral with a GCD (greatest common divisor) accelerator, on a simple strobe-based system bus.
- Host writes operands A1 and A2, the block computes W = gcd(A1, A2) by iterative subtraction, and the host polls status S and reads W.
- The result is also presented on gpio_out; the gpio_in bus is snapshotted on a latch strobe for inspection.

Parameters:
- ADDR_A1, 16'h00F8, address of operand register A1 (read/write).
- ADDR_A2, 16'h00FC, address of operand register A2 (read/write); a write starts the computation.
- ADDR_W, 16'h0100, address of result register W (read-only).
- ADDR_S, 16'h0104, address of status register S (read-only).

Ports:
- clk  in  1  system clock; all state changes on the rising edge except reset.
- n_reset  in  1  asynchronous, active-high reset (asserted when 1, despite the name); clears all state immediately.
- saddress  in  16  bus address, sampled with the strobes.
- srd  in  1  read strobe, active high.
- swr  in  1  write strobe, active high.
- sdata_in  in  32  write data.
- sdata_out  out  32  registered read data.
- gpio_in  in  32  external GPIO input bus.
- gpio_latch  in  1  capture strobe for gpio_in.
- gpio_out  out  32  GPIO output; carries the last completed GCD result.
- gpio_in_s_insp  out  32  snapshot of gpio_in taken at the last gpio_latch event.

Behaviour:
- Reset (n_reset=1, asynchronous): clears A1, A2, W, S, sdata_out, gpio_out, gpio_in_s_insp, the working registers and the strobe history to 0; FSM goes to IDLE.
- Strobes:
  - srd, swr and gpio_latch are synchronised through one flop each plus a history flop.
  - An access is one rising edge of the synchronised strobe, so a strobe held for several clocks performs exactly one access.
  - Access latency is 2-3 clk after the strobe rises.
- Write to ADDR_A1 loads A1 = sdata_in. Write to ADDR_A2 loads A2 = sdata_in and starts the GCD.
- Writes to any other address are ignored.
- Read:
  - sdata_out is loaded with A1, A2, W or S according to saddress; unmapped addresses return 0.
  - sdata_out holds its value until the next read.
- S bit map:
  - bit0 busy.
  - bit1 done: set at completion, cleared on start.
  - bits31:2 read 0.
- FSM:
  - IDLE: on start, copy a=A1 and b=A2, set busy=1, done=0, go to RUN. If both operands are 0, W=0 and the block completes in the same step.
  - RUN, one step per clk:
    - if b==0 then W=a, done;
    - else if a==0 then W=b, done;
    - else if a==b then W=a, done;
    - else if a>b then a=a-b;
    - else b=b-a.
  - Completion: W updated, gpio_out=W, busy=0, done=1, return to IDLE.
- Latency: the number of subtraction steps plus 1 clk; 39/9 takes 6 subtractions.
- Arithmetic is 32-bit unsigned. Operands are never negative, so there is no overflow.
- Start while busy: the current computation is aborted and restarted with the current A1/A2, and W is not updated by the aborted run.
- Writing A1 while busy updates A1 only; the running computation uses its latched copies.
- Read during busy returns S with busy=1; W keeps the previous result.
- gpio_latch: each rising edge of the synchronised latch loads gpio_in_s_insp with gpio_in as sampled by the synchroniser.
- Reset mid-operation aborts everything immediately; W=0 and S=0 afterwards.
- Simultaneous srd and swr edges: the write is applied first and the read returns the post-write value.

Test Plan:
- Reset pulse, then read A1, A2, W and S -> all read 0; gpio_out=0 and gpio_in_s_insp=0.
- Write A1=0x27 to 0xF8, write A2=0x9 to 0xFC, wait 40 clk, then read 0x100, 0x104, 0xF8 and 0xFC -> reads return 0x3, 0x2, 0x27 and 0x9 respectively; gpio_out=0x3.
- Poll S immediately after the A2 write -> 0x1 (busy) before completion and 0x2 after; W holds the previous value while busy.
- Write A1=0, A2=0x15 -> W=0x15. Write A1=0, A2=0 -> W=0. Write A1=0xFFFFFFFF, A2=0xFFFFFFFF -> W=0xFFFFFFFF after 1 step.
- Write A2 mid-run (A1=0x27, A2=0x9, then A2=0x1A within 2 clk) -> W=0xD and done; assert reset mid-run -> S=0 and W=0.
- gpio_in=0xA5A5_0001 with a gpio_latch pulse, then change gpio_in -> gpio_in_s_insp stays 0xA5A50001; a held swr performs a single write; a read of unmapped address 0x200 returns 0.
